// File: rtl/cache_pkg.sv
// Shared definitions for the cache line refill path: default geometry
// constants and the refill controller state encoding.
package cache_pkg;

  // Default cache geometry
  localparam int unsigned TAG_W_DEF  = 8;
  localparam int unsigned IDX_W_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BEATS_DEF  = 4;

  // Refill controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_FILL   = 2'd2,
    ST_UPDATE = 2'd3
  } refill_state_e;

endpackage

// File: rtl/refill_beat_counter.sv
// Beat slot counter for a line refill. Cleared when the line request is
// accepted, advanced once per accepted response beat, and flags the final
// beat of the line so the controller can move on to the tag update.
module refill_beat_counter
  import cache_pkg::*;
#(
  parameter  int unsigned BEATS  = BEATS_DEF,
  localparam int unsigned BEAT_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [BEAT_W-1:0] count_o,
  output logic              last_o
);

  logic [BEAT_W-1:0] count_q;
  logic [BEAT_W-1:0] count_d;

  // Next count: clear has priority over advance
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + BEAT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller. On a miss pulse it captures the missing
// tag/index, issues one line fetch to memory, streams the returned beats into
// the data array, then installs the tag (which marks the line valid).
// Misses arriving while busy and response beats arriving outside the fill
// phase are dropped and recorded in a sticky error flag.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter  int unsigned TAG_W  = TAG_W_DEF,
  parameter  int unsigned IDX_W  = IDX_W_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned BEATS  = BEATS_DEF,
  localparam int unsigned BEAT_W = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss,
  input  logic [TAG_W-1:0]       req_tag,
  input  logic [IDX_W-1:0]       req_index,
  output logic                   stall,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [TAG_W+IDX_W-1:0] mem_req_addr,
  input  logic                   mem_rsp_valid,
  input  logic [DATA_W-1:0]      mem_rsp_data,
  output logic                   data_we,
  output logic [IDX_W-1:0]       data_wr_index,
  output logic [BEAT_W-1:0]      data_wr_beat,
  output logic [DATA_W-1:0]      data_wr_data,
  output logic                   tag_we,
  output logic [IDX_W-1:0]       tag_wr_index,
  output logic [TAG_W-1:0]       tag_wr_tag,
  output logic                   refill_done,
  output logic                   err
);

  refill_state_e     state_q;
  refill_state_e     state_d;
  logic [TAG_W-1:0]  cap_tag_q;
  logic [TAG_W-1:0]  cap_tag_d;
  logic [IDX_W-1:0]  cap_idx_q;
  logic [IDX_W-1:0]  cap_idx_d;
  logic              err_q;
  logic              err_d;
  logic              stall_q;
  logic              req_vld_q;
  logic              upd_q;

  logic              fill_beat;
  logic              req_accept;
  logic [BEAT_W-1:0] beat_cnt;
  logic              beat_last;

  // A response beat is only consumed while filling; elsewhere it is a stray
  assign fill_beat  = (state_q == ST_FILL) && mem_rsp_valid;
  // The request is held in REQ, so ready alone completes the handshake
  assign req_accept = (state_q == ST_REQ) && mem_req_ready;

  refill_beat_counter #(
    .BEATS (BEATS)
  ) u_beat_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (req_accept),
    .en_i    (fill_beat),
    .count_o (beat_cnt),
    .last_o  (beat_last)
  );

  // Next-state logic of the refill sequence
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (miss)                   state_d = ST_REQ;
      ST_REQ:    if (mem_req_ready)          state_d = ST_FILL;
      ST_FILL:   if (fill_beat && beat_last) state_d = ST_UPDATE;
      ST_UPDATE:                             state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // State register with registered state-decoded outputs, so stall never
  // depends combinationally on miss
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      stall_q   <= 1'b0;
      req_vld_q <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= (state_d != ST_IDLE);
      req_vld_q <= (state_d == ST_REQ);
      upd_q     <= (state_d == ST_UPDATE);
    end
  end

  // Capture the missing address only when idle; later misses are dropped
  // and protocol violations latch the sticky error
  always_comb begin
    cap_tag_d = cap_tag_q;
    cap_idx_d = cap_idx_q;
    err_d     = err_q;
    if ((state_q == ST_IDLE) && miss) begin
      cap_tag_d = req_tag;
      cap_idx_d = req_index;
    end
    if (miss && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end
    if (mem_rsp_valid && (state_q != ST_FILL)) begin
      err_d = 1'b1;
    end
  end

  // Captured address and error flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_tag_q <= '0;
      cap_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cap_tag_q <= cap_tag_d;
      cap_idx_q <= cap_idx_d;
      err_q     <= err_d;
    end
  end

  assign stall         = stall_q;
  assign mem_req_valid = req_vld_q;
  assign mem_req_addr  = {cap_tag_q, cap_idx_q};

  // Beat writes go straight through in the cycle the beat arrives; data is
  // gated so nothing leaks onto the write bus when no write is happening
  assign data_we       = fill_beat;
  assign data_wr_index = cap_idx_q;
  assign data_wr_beat  = beat_cnt;
  assign data_wr_data  = fill_beat ? mem_rsp_data : '0;

  assign tag_we        = upd_q;
  assign tag_wr_index  = cap_idx_q;
  assign tag_wr_tag    = cap_tag_q;
  assign refill_done   = upd_q;
  assign err           = err_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized self-checking bench for cache_refill_ctrl. The bench plays the
// upstream miss source and the memory; each refill is driven as a
// transaction whose expected per-cycle outputs follow from the stimulus it
// chose (request wait, beat gaps, injected misses/strays, resets). Installed
// lines are tracked in a tag/valid table and compared against what the DUT
// actually wrote.
module tb_cache_refill_ctrl;

  localparam int TAG_W  = 8;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 32;
  localparam int BEATS  = 4;
  localparam int BEAT_W = 2;
  localparam int LINES  = 1 << IDX_W;

  logic                   clk;
  logic                   reset;
  logic                   miss;
  logic [TAG_W-1:0]       req_tag;
  logic [IDX_W-1:0]       req_index;
  logic                   stall;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [TAG_W+IDX_W-1:0] mem_req_addr;
  logic                   mem_rsp_valid;
  logic [DATA_W-1:0]      mem_rsp_data;
  logic                   data_we;
  logic [IDX_W-1:0]       data_wr_index;
  logic [BEAT_W-1:0]      data_wr_beat;
  logic [DATA_W-1:0]      data_wr_data;
  logic                   tag_we;
  logic [IDX_W-1:0]       tag_wr_index;
  logic [TAG_W-1:0]       tag_wr_tag;
  logic                   refill_done;
  logic                   err;

  cache_refill_ctrl #(
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W),
    .BEATS  (BEATS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .miss          (miss),
    .req_tag       (req_tag),
    .req_index     (req_index),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .data_we       (data_we),
    .data_wr_index (data_wr_index),
    .data_wr_beat  (data_wr_beat),
    .data_wr_data  (data_wr_data),
    .tag_we        (tag_we),
    .tag_wr_index  (tag_wr_index),
    .tag_wr_tag    (tag_wr_tag),
    .refill_done   (refill_done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: expected error flag and expected installed lines
  logic             err_exp;
  logic             exp_vld [LINES];
  logic [TAG_W-1:0] exp_tag [LINES];
  // Lines the DUT actually installed, as seen on the tag write port
  logic             seen_vld [LINES];
  logic [TAG_W-1:0] seen_tag [LINES];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe/status expectations for the current cycle
  task automatic chk_cycle(input string ph, input logic e_stall, input logic e_rv,
                           input logic e_dwe, input logic e_upd);
    chk({ph, ".stall"},   64'(stall),         64'(e_stall));
    chk({ph, ".req_vld"}, 64'(mem_req_valid), 64'(e_rv));
    chk({ph, ".data_we"}, 64'(data_we),       64'(e_dwe));
    chk({ph, ".tag_we"},  64'(tag_we),        64'(e_upd));
    chk({ph, ".done"},    64'(refill_done),   64'(e_upd));
    chk({ph, ".err"},     64'(err),           64'(err_exp));
  endtask

  // Record tag installs away from the active edge
  always @(negedge clk) begin
    if (tag_we === 1'b1) begin
      seen_vld[tag_wr_index] = 1'b1;
      seen_tag[tag_wr_index] = tag_wr_tag;
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    miss = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    err_exp = 1'b0;
    #1;
    chk_cycle("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk_cycle("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stray_idle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = $urandom;
    #1;
    chk_cycle("stray", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stray.wdata", 64'(data_wr_data), 64'(0));
    tick();
    err_exp = 1'b1;
    mem_rsp_valid = 1'b0;
    #1;
    chk("stray.err", 64'(err), 64'(1));
  endtask

  // One refill transaction. rdly: cycles ready is held low; gap_lo/hi: idle
  // cycles before each beat; miss_beat: -2 = extra miss in REQ, 0..BEATS-1 =
  // extra miss alongside that beat, -1 = none; rst_beat: reset after that
  // beat (-1 = none); stray_req: response beat injected in REQ.
  task automatic do_refill(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] ix,
                           input int rdly, input int gap_lo, input int gap_hi,
                           input int miss_beat, input int rst_beat, input bit stray_req);
    int gap;
    logic [DATA_W-1:0] d;
    miss = 1'b1;
    req_tag = t;
    req_index = ix;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    #1;
    chk_cycle("miss", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    miss = 1'b0;
    req_tag = 8'($urandom);
    req_index = 4'($urandom);
    for (int c = 0; c <= rdly; c++) begin
      mem_req_ready = (c == rdly);
      if (stray_req && c == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = $urandom;
      end
      if (miss_beat == -2 && c == 0) begin
        miss = 1'b1;
        req_tag = ~t;
        req_index = ix + 4'd1;
      end
      #1;
      chk_cycle("req", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("req.addr", 64'(mem_req_addr), 64'({t, ix}));
      tick();
      if (mem_rsp_valid || miss) err_exp = 1'b1;
      mem_rsp_valid = 1'b0;
      miss = 1'b0;
    end
    mem_req_ready = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      gap = int'($urandom_range(gap_hi, gap_lo));
      for (int g = 0; g < gap; g++) begin
        #1;
        chk_cycle("gap", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
      end
      d = $urandom;
      mem_rsp_valid = 1'b1;
      mem_rsp_data = d;
      if (miss_beat == k) begin
        miss = 1'b1;
        req_tag = ~t;
        req_index = ix + 4'd1;
      end
      #1;
      chk_cycle("beat", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("beat.slot", 64'(data_wr_beat), 64'(k));
      chk("beat.line", 64'(data_wr_index), 64'(ix));
      chk("beat.data", 64'(data_wr_data), 64'(d));
      tick();
      if (miss) err_exp = 1'b1;
      miss = 1'b0;
      mem_rsp_valid = 1'b0;
      if (rst_beat == k) begin
        pulse_reset();
        chk("abandon.line_vld", 64'(seen_vld[ix]), 64'(exp_vld[ix]));
        return;
      end
    end
    #1;
    chk_cycle("upd", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("upd.tag", 64'(tag_wr_tag), 64'(t));
    chk("upd.line", 64'(tag_wr_index), 64'(ix));
    tick();
    exp_vld[ix] = 1'b1;
    exp_tag[ix] = t;
    chk_cycle("after", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < LINES; i++) begin
      exp_vld[i] = 1'b0;
      exp_tag[i] = '0;
      seen_vld[i] = 1'b0;
      seen_tag[i] = '0;
    end
    err_exp = 1'b0;
    // Reset with busy-looking inputs: every output must stay low
    reset = 1'b1;
    miss = 1'b1;
    req_tag = 8'hFF;
    req_index = 4'hF;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 32'hFFFF_FFFF;
    tick();
    tick();
    chk_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.addr", 64'(mem_req_addr), 64'(0));
    chk("reset.wdata", 64'(data_wr_data), 64'(0));
    chk("reset.wslot", 64'(data_wr_beat), 64'(0));
    miss = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Back-to-back refill: done in cycle BEATS+2, stall low in BEATS+3
    do_refill(8'h5A, 4'h3, 0, 0, 0, -1, -1, 1'b0);
    // Memory holds off the request for 5 cycles
    do_refill(8'hC3, 4'h1, 5, 0, 0, -1, -1, 1'b0);
    // Two idle cycles ahead of every beat
    do_refill(8'h17, 4'h2, 0, 2, 2, -1, -1, 1'b0);
    // Second miss during FILL is dropped and flags an error
    do_refill(8'h88, 4'h5, 1, 0, 1, 1, -1, 1'b0);
    pulse_reset();
    // Stray response while idle
    stray_idle();
    pulse_reset();
    // Reset after beat 2 abandons the line; next miss refills normally
    do_refill(8'h3C, 4'hE, 0, 0, 0, -1, 2, 1'b0);
    chk("abandon.err", 64'(err), 64'(0));
    do_refill(8'h42, 4'h7, 0, 0, 1, -1, -1, 1'b0);

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      int mb;
      int rb;
      mb = ($urandom_range(4, 0) == 0) ? int'($urandom_range(5, 0)) - 2 : -1;
      rb = ($urandom_range(7, 0) == 0) ? int'($urandom_range(BEATS - 1, 0)) : -1;
      do_refill(8'($urandom), 4'($urandom), int'($urandom_range(3, 0)), 0,
                int'($urandom_range(2, 0)), mb, rb, ($urandom_range(5, 0) == 0));
      if ($urandom_range(5, 0) == 0) stray_idle();
      if (err_exp && $urandom_range(3, 0) == 0) pulse_reset();
    end

    // Installed line table must match the transactions that completed
    for (int i = 0; i < LINES; i++) begin
      chk($sformatf("table.vld[%0d]", i), 64'(seen_vld[i]), 64'(exp_vld[i]));
      if (exp_vld[i]) chk($sformatf("table.tag[%0d]", i), 64'(seen_tag[i]), 64'(exp_tag[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
